seq_divider: RTL and testbench

Multi-cycle restoring integer divider for the MIPS CPU execute stage, serving DIV/DIVU and writing HI (remainder) and LO (quotient). It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. Each trial subtraction uses the existing `addsub` unit. Results are held stable until the next completed operation.

---
 rtl/div_pkg.sv | 14 +
 rtl/addsub.sv | 20 ++
 rtl/seq_divider.sv | 160 ++++++++++++++++
 tb/tb_seq_divider.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_t;

    localparam int unsigned DIV_N_DEFAULT = 32;
    localparam logic [DIV_N_DEFAULT-1:0] DIV_ZERO_QUO = '1;

    // Iteration counter width: $clog2(n), never below one bit.
    function automatic int unsigned div_cnt_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub.sv
// Adder/subtractor: Result = A + B, or A - B when Subtract=1 (FlagC=1 means no borrow).
module addsub #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Subtract,
    output logic [N-1:0] Result,
    output logic         FlagC
);

    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;

    assign w_b_eff = B ^ {N{Subtract}};
    assign w_sum   = {1'b0, A} + {1'b0, w_b_eff} + {{N{1'b0}}, Subtract};
    assign Result  = w_sum[N-1:0];
    assign FlagC   = w_sum[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per clock.
// Signed support is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Start,
    input  logic         Signed,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         FlagDivZero
);

    localparam int unsigned CntW = div_cnt_w(N);

    div_state_t      r_state;
    logic [CntW-1:0] r_cnt;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_quo;
    logic [N-1:0]    r_div;
    logic            r_dz;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_flag_dz;

    logic [N-1:0]    w_a_mag;
    logic [N-1:0]    w_b_mag;
    logic [N-1:0]    w_quo_fin;
    logic [N-1:0]    w_rem_fin;
    logic            w_b_zero;
    logic            w_accept;
    logic [N:0]      w_trial_a;
    logic [N:0]      w_trial_b;
    logic [N:0]      w_trial_res;
    logic            w_no_borrow;
    logic            w_unused_msb;

    assign w_b_zero = (B == '0);
    assign w_accept = (r_state == IDLE) && Start;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic r_sign_q;
    logic r_sign_r;
    logic w_neg_a;
    logic w_neg_b;

    assign w_neg_a   = Signed & A[N-1];
    assign w_neg_b   = Signed & B[N-1];
    assign w_a_mag   = w_neg_a ? -A : A;
    assign w_b_mag   = w_neg_b ? -B : B;
    assign w_quo_fin = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fin = r_sign_r ? -r_rem : r_rem;

    // Divide-by-zero returns raw operands, so signs are cleared on that path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
        end else if (w_accept) begin
            r_sign_q <= w_b_zero ? 1'b0 : (w_neg_a ^ w_neg_b);
            r_sign_r <= w_b_zero ? 1'b0 : w_neg_a;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = Signed;
    assign w_a_mag         = A;
    assign w_b_mag         = B;
    assign w_quo_fin       = r_quo;
    assign w_rem_fin       = r_rem;
`endif

    // Shifted partial remainder needs N+1 bits before the trial subtract.
    assign w_trial_a    = {r_rem, r_quo[N-1]};
    assign w_trial_b    = {1'b0, r_div};
    assign w_unused_msb = w_trial_res[N];

    addsub #(
        .N (N + 1)
    ) u_addsub (
        .A        (w_trial_a),
        .B        (w_trial_b),
        .Subtract (1'b1),
        .Result   (w_trial_res),
        .FlagC    (w_no_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_dz        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_flag_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_busy <= 1'b1;
                        r_dz   <= w_b_zero;
                        r_cnt  <= CntW'(N - 1);
                        if (w_b_zero) begin
                            r_quo   <= {N{DIV_ZERO_QUO[0]}};
                            r_rem   <= A;
                            r_state <= FIN;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                            r_div   <= w_b_mag;
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_no_borrow ? w_trial_res[N-1:0] : w_trial_a[N-1:0];
                    r_quo <= {r_quo[N-2:0], w_no_borrow};
                    r_cnt <= r_cnt - CntW'(1);
                    if (r_cnt == '0) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_quotient  <= w_quo_fin;
                    r_remainder <= w_rem_fin;
                    r_flag_dz   <= r_dz;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Quotient    = r_quotient;
    assign Remainder   = r_remainder;
    assign FlagDivZero = r_flag_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, random ops vs. arithmetic model,
// and hand-written busy/back-to-back/reset sequences. Honours SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int unsigned N = 32;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic          Signed;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          Busy;
    logic          Done;
    logic [N-1:0]  Quotient;
    logic [N-1:0]  Remainder;
    logic          FlagDivZero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    seq_divider #(
        .N (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Start       (Start),
        .Signed      (Signed),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .FlagDivZero (FlagDivZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: divide magnitudes with plain arithmetic, then apply sign rules.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output bit dz);
        bit sg;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned q0;
        longint unsigned r0;
        sg = s && SignedEn;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
            return;
        end
        dz = 1'b0;
        ma = (sg && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = (sg && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q0 = ma / mb;
        r0 = ma % mb;
        q  = (sg && (a[31] ^ b[31])) ? 32'(64'd0 - q0) : q0[31:0];
        r  = (sg && a[31]) ? 32'(64'd0 - r0) : r0[31:0];
    endfunction

    // Issue one op; returns results at the negedge of the Done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input bit now, output logic [31:0] q, output logic [31:0] r,
                          output bit dz, output int lat, output bit busy0);
        if (!now) @(negedge clk);
        Start  = 1'b1;
        A      = a;
        B      = b;
        Signed = s;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        busy0 = Busy;
        lat   = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (Done) break;
        end
        q  = Quotient;
        r  = Remainder;
        dz = FlagDivZero;
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] eq;
        logic [31:0] er;
        bit          dz;
        bit          edz;
        bit          busy0;
        int          lat;
        int          dones;

        vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33};
        vecs[1] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
        vecs[5] = '{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 33};
        vecs[6] = '{32'h1234_5678, 32'h1000, 1'b0, 32'h0001_2345, 32'h678, 1'b0, 33};
        vecs[8] = '{32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1, 1};
        vecs[9] = '{32'd3, 32'd5, 1'b0, 32'd0, 32'd3, 1'b0, 33};
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[2] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33};
        vecs[7] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33};
`else
        vecs[2] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33};
        vecs[7] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 33};
`endif

        rst_n  = 1'b0;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_quo", Quotient, 32'd0);
        check("reset_rem", Remainder, 32'd0);
        check("reset_dz", {31'd0, FlagDivZero}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, q, r, dz, lat, busy0);
            check($sformatf("vec%0d_busy", i), {31'd0, busy0}, 32'd1);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_quo", i), q, vecs[i].q);
            check($sformatf("vec%0d_rem", i), r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            check($sformatf("vec%0d_busy_done", i), {31'd0, Busy}, 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_drop", i), {31'd0, Done}, 32'd0);
            check($sformatf("vec%0d_hold", i), Quotient, vecs[i].q);
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            bit          rs;
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2, 3: rb = 32'($urandom_range(1, 255));
                4:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            ref_div(ra, rb, rs, eq, er, edz);
            run_op(ra, rb, rs, 1'b0, q, r, dz, lat, busy0);
            check($sformatf("rnd%0d_lat", i), 32'(lat), edz ? 32'd1 : 32'd33);
            check($sformatf("rnd%0d_quo", i), q, eq);
            check($sformatf("rnd%0d_rem", i), r, er);
            check($sformatf("rnd%0d_dz", i), {31'd0, dz}, {31'd0, edz});
        end

        // Start during Busy is ignored; Start in the Done cycle is accepted.
        @(negedge clk);
        Start  = 1'b1;
        A      = 32'd100;
        B      = 32'd7;
        Signed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (lat < 100) begin
            if (lat == 4) begin
                Start = 1'b1;
                A     = 32'd9;
                B     = 32'd3;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (Done) break;
        end
        check("busy_ign_lat", 32'(lat), 32'd33);
        check("busy_ign_quo", Quotient, 32'd14);
        check("busy_ign_rem", Remainder, 32'd2);
        run_op(32'd9, 32'd3, 1'b0, 1'b1, q, r, dz, lat, busy0);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_quo", q, 32'd3);
        check("b2b_rem", r, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) dones++;
        end
        check("no_extra_done", 32'(dones), 32'd0);

        // Reset at E10 of a running operation.
        @(negedge clk);
        Start = 1'b1;
        A     = 32'd1000;
        B     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_done", {31'd0, Done}, 32'd0);
        check("rst_mid_quo", Quotient, 32'd0);
        check("rst_mid_rem", Remainder, 32'd0);
        check("rst_mid_dz", {31'd0, FlagDivZero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) dones++;
        end
        check("rst_no_done", 32'(dones), 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 1'b0, q, r, dz, lat, busy0);
        check("post_rst_lat", 32'(lat), 32'd33);
        check("post_rst_quo", q, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
